mdu_iterative: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It replaces the single-shot HI/LO unit with a shift-add multiplier, configurable to 1, 2 or 4 bits per cycle, and a 1-bit-per-cycle restoring divider. It adds a Done pulse, a divide-by-zero flag and a Cancel input for exception flush. HI/LO are committed only on completion, so a cancelled operation leaves both registers untouched.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_if.sv | 25 ++
 rtl/mdu_div_step.sv | 24 ++
 rtl/mdu_iterative.sv | 216 +++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and a two's-complement magnitude helper.
package mdu_pkg;

  // Widest operand the magnitude helper can handle.
  localparam int MAX_W = 64;

  localparam logic [2:0] OP_DIV   = 3'b000;
  localparam logic [2:0] OP_DIVU  = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  // Absolute value of a sign-extended operand when the operation is signed;
  // unsigned operations pass the value through. Callers truncate to WIDTH.
  function automatic logic [MAX_W-1:0] twos_mag(input logic signed [MAX_W-1:0] v,
                                                input logic                    is_signed);
    return (is_signed && v[MAX_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mdu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, mdu_op, a, b, cancel,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, mdu_op, a, b, cancel,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not go negative and report that outcome as the quotient bit.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // The partial remainder is always below the divisor, so the shifted value
  // fits WIDTH+1 bits and a borrow shows up in the top bit of the difference.
  assign w_shift = {i_rem, i_bit};
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign o_q     = ~w_trial[WIDTH];
  assign o_rem   = o_q ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative HI/LO unit: shift-add multiplier retiring MUL_STEP bits per cycle
// and a 1-bit-per-cycle restoring divider. Operands are reduced to magnitudes
// on issue, signs are re-applied in FIX, and HI/LO change only at commit so a
// cancelled operation leaves them untouched.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input logic  i_clk,
  input logic  i_rst_n,
  mdu_if.slave io_bus
);

  localparam int MUL_CNT = WIDTH / MUL_STEP;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  generate
    if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4) || (WIDTH % MUL_STEP) != 0 ||
        (WIDTH % 2) != 0 || WIDTH < 8 || WIDTH > MAX_W) begin : g_bad_cfg
      $error("mdu_iterative: unsupported WIDTH/MUL_STEP combination");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;       // {HI half, LO half}: product or {remainder, quotient}
  logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
  logic               r_is_mul;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic w_load_mul, w_load_div, w_load_dz, w_step, w_commit, w_wr_hi, w_wr_lo;

  // Operand preparation at issue
  logic                    w_signed_op;
  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0]        w_a_mag;
  logic [WIDTH-1:0]        w_b_mag;
  logic                    w_sa;
  logic                    w_sb;

  assign w_signed_op = (io_bus.mdu_op == OP_DIV) || (io_bus.mdu_op == OP_MULT);
  assign w_a_s       = io_bus.a;
  assign w_b_s       = io_bus.b;
  assign w_a_mag     = WIDTH'(twos_mag(MAX_W'(w_a_s), w_signed_op));
  assign w_b_mag     = WIDTH'(twos_mag(MAX_W'(w_b_s), w_signed_op));
  assign w_sa        = w_signed_op & io_bus.a[WIDTH-1];
  assign w_sb        = w_signed_op & io_bus.b[WIDTH-1];

  // Multiplier step: add multiplicand * low digit into the upper half, then
  // shift the accumulator right by MUL_STEP. The sum cannot exceed WIDTH+MUL_STEP bits.
  logic [MUL_STEP-1:0]       w_digit;
  logic [WIDTH+MUL_STEP-1:0] w_pp_sum;
  logic [2*WIDTH-1:0]        w_mul_nxt;

  assign w_digit   = r_acc[MUL_STEP-1:0];
  assign w_pp_sum  = {{MUL_STEP{1'b0}}, r_acc[2*WIDTH-1:WIDTH]}
                   + ((WIDTH+MUL_STEP)'(r_opnd) * (WIDTH+MUL_STEP)'(w_digit));
  assign w_mul_nxt = {w_pp_sum, r_acc[WIDTH-1:MUL_STEP]};

  // Divider step: dividend bits leave the top of the LO half while quotient
  // bits enter at the bottom.
  logic [WIDTH-1:0]   w_rem_nxt;
  logic               w_q;
  logic [2*WIDTH-1:0] w_div_nxt;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_bit     (r_acc[WIDTH-1]),
    .i_divisor (r_opnd),
    .o_rem     (w_rem_nxt),
    .o_q       (w_q)
  );

  assign w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], w_q};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_acc_hi;
  logic [WIDTH-1:0]   w_acc_lo;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
  assign w_acc_hi   = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo   = r_acc[WIDTH-1:0];
  assign w_hi_fix   = r_is_mul ? w_prod_fix[2*WIDTH-1:WIDTH] : (r_neg_hi ? -w_acc_hi : w_acc_hi);
  assign w_lo_fix   = r_is_mul ? w_prod_fix[WIDTH-1:0]       : (r_neg_lo ? -w_acc_lo : w_acc_lo);

  // Controller state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control strobes; Cancel wins over everything
  always_comb begin
    w_state_nxt = r_state;
    w_load_mul  = 1'b0;
    w_load_div  = 1'b0;
    w_load_dz   = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start && !io_bus.cancel) begin
          case (io_bus.mdu_op)
            OP_MULT, OP_MULTU: begin
              w_load_mul  = 1'b1;
              w_state_nxt = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (io_bus.b == '0) begin
                w_load_dz   = 1'b1;
                w_state_nxt = ST_FIX;
              end else begin
                w_load_div  = 1'b1;
                w_state_nxt = ST_DIV;
              end
            end
            OP_MTHI: w_wr_hi = 1'b1;
            OP_MTLO: w_wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (io_bus.cancel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_commit    = !io_bus.cancel;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Iteration counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_cnt <= '0;
    else if (w_load_mul) r_cnt <= CNT_W'(MUL_CNT);
    else if (w_load_div) r_cnt <= CNT_W'(WIDTH);
    else if (w_step)     r_cnt <= r_cnt - CNT_W'(1);
  end

  // Working datapath: operand latch on issue, one iteration per busy cycle.
  // Divide by zero preloads the final {HI, LO} = {A, all ones} with no correction.
  always_ff @(posedge i_clk) begin
    if (w_load_mul) begin
      r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
      r_opnd   <= w_a_mag;
      r_is_mul <= 1'b1;
      r_dz     <= 1'b0;
      r_neg_lo <= w_sa ^ w_sb;
      r_neg_hi <= w_sa ^ w_sb;
    end else if (w_load_div) begin
      r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
      r_opnd   <= w_b_mag;
      r_is_mul <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_lo <= w_sa ^ w_sb;
      r_neg_hi <= w_sa;
    end else if (w_load_dz) begin
      r_acc    <= {io_bus.a, {WIDTH{1'b1}}};
      r_is_mul <= 1'b0;
      r_dz     <= 1'b1;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else if (w_step) begin
      r_acc    <= r_is_mul ? w_mul_nxt : w_div_nxt;
    end
  end

  // Architectural HI/LO and the completion pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= w_commit;
      r_div_zero <= w_commit & r_dz;
      if (w_commit) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end else begin
        if (w_wr_hi) r_hi <= io_bus.a;
        if (w_wr_lo) r_lo <= io_bus.a;
      end
    end
  end

  assign io_bus.hi       = r_hi;
  assign io_bus.lo       = r_lo;
  assign io_bus.busy     = (r_state != ST_IDLE);
  assign io_bus.done     = r_done;
  assign io_bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: two instances (MUL_STEP 1 and 4) share one stimulus
// stream; a transaction-level model predicts HI/LO/Busy/Done/DivZero from
// plain 64-bit arithmetic and the documented latencies.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus1 ();
  mdu_if #(.WIDTH(32)) bus4 ();

  assign bus1.start  = start;
  assign bus1.mdu_op = op;
  assign bus1.a      = a;
  assign bus1.b      = b;
  assign bus1.cancel = cancel;
  assign bus4.start  = start;
  assign bus4.mdu_op = op;
  assign bus4.a      = a;
  assign bus4.b      = b;
  assign bus4.cancel = cancel;

  mdu_iterative #(.WIDTH(32), .MUL_STEP(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus1));
  mdu_iterative #(.WIDTH(32), .MUL_STEP(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain arithmetic
  task automatic ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    if (o[1]) begin
      if (o[0]) begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      else      begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
    end else if (y == 0) begin
      rh = x; rl = 32'hFFFF_FFFF; rdz = 1'b1;
    end else if (o[0]) begin
      up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0];
    end else begin
      sq = sx / sy; sr = sx % sy; rl = sq[31:0]; rh = sr[31:0];
    end
  endtask

  // Model state per instance: [0] MUL_STEP=1, [1] MUL_STEP=4
  int          mul_lat [2] = '{33, 9};
  int          m_cnt   [2];
  logic [31:0] m_hi    [2];
  logic [31:0] m_lo    [2];
  logic        m_done  [2];
  logic        m_dz    [2];
  logic [31:0] p_hi    [2];
  logic [31:0] p_lo    [2];
  logic        p_dz    [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0; m_hi[k] = '0; m_lo[k] = '0; m_done[k] = 1'b0; m_dz[k] = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        m_dz[k]   = 1'b0;
        if (m_cnt[k] > 0) begin
          if (cancel) m_cnt[k] = 0;
          else begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
              m_hi[k] = p_hi[k]; m_lo[k] = p_lo[k]; m_done[k] = 1'b1; m_dz[k] = p_dz[k];
            end
          end
        end else if (start && !cancel) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              ref_op(op, a, b, p_hi[k], p_lo[k], p_dz[k]);
              m_cnt[k] = op[1] ? mul_lat[k] : ((b == 0) ? 1 : 33);
            end
            3'd4: m_hi[k] = a;
            3'd5: m_lo[k] = a;
            default: ;
          endcase
        end
      end
    end
  end

  // Continuous comparison away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("hi1", bus1.hi, m_hi[0]);
      chk("lo1", bus1.lo, m_lo[0]);
      chk("busy1", 32'(bus1.busy), 32'(m_cnt[0] != 0));
      chk("done1", 32'(bus1.done), 32'(m_done[0]));
      chk("dz1", 32'(bus1.div_zero), 32'(m_dz[0]));
      chk("hi4", bus4.hi, m_hi[1]);
      chk("lo4", bus4.lo, m_lo[1]);
      chk("busy4", 32'(bus4.busy), 32'(m_cnt[1] != 0));
      chk("done4", 32'(bus4.done), 32'(m_done[1]));
      chk("dz4", 32'(bus4.div_zero), 32'(m_dz[1]));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edge numbers (relative to the issue edge) at which each instance commits;
  // returns at the falling edge inside the later Done cycle, -1 if never seen.
  task automatic wait_done(input int base, output int e1, output int e4);
    e1 = -1; e4 = -1;
    for (int n = base + 1; n <= base + 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.done && e1 < 0) e1 = n;
      if (bus4.done && e4 < 0) e4 = n;
      if (e1 >= 0 && e4 >= 0) break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int e1, e4, cyc, poke_at, cancel_at, gap;

    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_hi", bus1.hi, 32'h0);
    chk("rst_lo", bus1.lo, 32'h0);
    chk("rst_busy", 32'(bus1.busy), 32'h0);
    chk("rst_done", 32'(bus1.done), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Signed multiply with one negative operand
    issue(3'b010, 32'hFFFF_FFFD, 32'd5);
    wait_done(0, e1, e4);
    chk("mult_edge_s1", 32'(e1), 32'd33);
    chk("mult_edge_s4", 32'(e4), 32'd9);
    chk("mult_hi1", bus1.hi, 32'hFFFF_FFFF);
    chk("mult_lo1", bus1.lo, 32'hFFFF_FFF1);
    chk("mult_hi4", bus4.hi, 32'hFFFF_FFFF);
    chk("mult_lo4", bus4.lo, 32'hFFFF_FFF1);
    @(posedge clk);
    #1;

    // Unsigned divide with an MTHI attempt while busy, then back-to-back issue
    issue(3'b001, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'b100; a = 32'h0000_DEAD;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4, e1, e4);
    chk("divu_edge", 32'(e1), 32'd33);
    chk("divu_lo", bus1.lo, 32'd14);
    chk("divu_hi", bus1.hi, 32'd2);
    issue(3'b000, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, e1, e4);
    chk("div_b2b_edge", 32'(e1), 32'd33);
    chk("div_neg_lo", bus1.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus1.hi, 32'hFFFF_FFFF);

    // Divide by zero
    issue(3'b000, 32'h0000_1234, 32'h0);
    wait_done(0, e1, e4);
    chk("dz_edge", 32'(e1), 32'd1);
    chk("dz_flag", 32'(bus1.div_zero), 32'd1);
    chk("dz_hi", bus1.hi, 32'h0000_1234);
    chk("dz_lo", bus1.lo, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("dz_done_clear", 32'(bus1.done), 32'd0);
    chk("dz_flag_clear", 32'(bus1.div_zero), 32'd0);

    // Most-negative divided by minus one
    issue(3'b000, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, e1, e4);
    chk("ovf_lo", bus1.lo, 32'h8000_0000);
    chk("ovf_hi", bus1.hi, 32'h0);
    @(posedge clk);
    #1;

    // Preload HI/LO, then cancel a multiply
    issue(3'b100, 32'h0000_AAAA, 32'h0);
    chk("mthi", bus1.hi, 32'h0000_AAAA);
    issue(3'b101, 32'h0000_5555, 32'h0);
    chk("mtlo", bus1.lo, 32'h0000_5555);
    issue(3'b011, 32'd12345, 32'd678);
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk);
    chk("cancel_busy_before", 32'(bus1.busy), 32'd1);
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy_after", 32'(bus1.busy), 32'd0);
    chk("cancel_done", 32'(bus1.done), 32'd0);
    chk("cancel_hi", bus1.hi, 32'h0000_AAAA);
    chk("cancel_lo", bus1.lo, 32'h0000_5555);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a divide
    issue(3'b001, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", bus1.hi, 32'h0);
    chk("arst_lo", bus1.lo, 32'h0);
    chk("arst_busy", 32'(bus1.busy), 32'h0);
    chk("arst_busy4", 32'(bus4.busy), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(3'b010, 32'hFFFF_FFFD, 32'd5);
    wait_done(0, e1, e4);
    chk("post_rst_edge", 32'(e1), 32'd33);
    chk("post_rst_lo", bus1.lo, 32'hFFFF_FFF1);
    @(posedge clk);
    #1;

    // Randomized operations, with occasional pokes while busy and cancels
    for (int t = 0; t < 150; t++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      poke_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      cancel_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : -1;
      cyc = 0;
      while ((m_cnt[0] != 0 || m_cnt[1] != 0) && cyc < 120) begin
        if (cyc == poke_at) begin
          start = 1'b1; op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
        end
        cancel = (cyc == cancel_at);
        @(posedge clk);
        #1 start = 1'b0;
        cancel = 1'b0;
        cyc++;
      end
      checks++;
      if (cyc >= 120) begin
        errors++;
        $display("FAIL rand_timeout: op %0d still busy after %0d cycles, limit 120", t, cyc);
      end
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
